// File: rtl/perip_sram_pkg.sv
// ============================================================================
// perip_sram_pkg : shared constants for the SRAM pin-bus responder model
// Rev 1.0
// ============================================================================
`default_nettype none

package perip_sram_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RD_WAIT   = 2'd1;
  localparam logic [1:0] ST_RD_VALID  = 2'd2;
  localparam logic [1:0] ST_WR_ACTIVE = 2'd3;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/perip_sram_array.sv
// ============================================================================
// perip_sram_array : 2**MEM_AW x DW word array, sync write, 1-cycle sync read
// Rev 1.0
// ============================================================================
`default_nettype none

module perip_sram_array #(
  parameter int MEM_AW = 10,
  parameter int DW     = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<MEM_AW)-1];
  logic [DW-1:0] rdata_q;

  // Write-first: a read colliding with the commit sees the new word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/perip_sram_responder.sv
// ============================================================================
// perip_sram_responder : device-side model of an async SRAM on the pin bus
// Rev 1.0
// ============================================================================
`default_nettype none

module perip_sram_responder
  import perip_sram_pkg::*;
#(
  parameter int AW     = 22,
  parameter int DW     = 16,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SRAM_CSn_io,
  input  logic          SRAM_OEn_io,
  input  logic          SRAM_WRn_io,
  input  logic [AW-1:0] SRAM_ADDR_io,
  input  logic [DW-1:0] SRAM_DATA_IN_io,
  input  logic [DW-1:0] SRAM_DATA_t,
  output logic [DW-1:0] SRAM_DATA_OUT_io,
  output logic          rd_valid,
  output logic          wr_commit,
  output logic          bus_conflict
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
    $error("perip_sram_responder: RD_LAT must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              conflict_q, conflict_d;

  logic          w_is_wr;
  logic          w_is_rd;
  logic          w_same_addr;
  logic          w_commit;
  logic          w_rd_valid;
  logic [DW-1:0] w_rdata;

  assign w_is_wr     = !SRAM_CSn_io && !SRAM_WRn_io;
  assign w_is_rd     = !SRAM_CSn_io && !SRAM_OEn_io && SRAM_WRn_io;
  assign w_same_addr = (SRAM_ADDR_io == rd_addr_q);
  assign w_rd_valid  = (state_q == ST_RD_VALID);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    w_commit  = 1'b0;

    case (state_q)
      ST_IDLE, ST_WR_ACTIVE: begin
        w_commit = (state_q == ST_WR_ACTIVE) && !w_is_wr;
        if (w_is_wr) begin
          state_d = ST_WR_ACTIVE;
        end else if (w_is_rd) begin
          rd_addr_d = SRAM_ADDR_io;
          cnt_d     = CNT_LOAD;
          state_d   = (RD_LAT == 1) ? ST_RD_VALID : ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (w_is_wr) begin
          state_d = ST_WR_ACTIVE;
        end else if (w_is_rd && w_same_addr) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ST_RD_VALID;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (w_is_rd) begin
          rd_addr_d = SRAM_ADDR_io;
          cnt_d     = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (w_is_wr) begin
          state_d = ST_WR_ACTIVE;
        end else if (w_is_rd && !w_same_addr) begin
          rd_addr_d = SRAM_ADDR_io;
          cnt_d     = CNT_LOAD;
          state_d   = ST_RD_WAIT;
        end else if (!w_is_rd) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // Every sampled write cycle overwrites the pending word; last sample wins.
    if (w_is_wr) begin
      wr_addr_d = SRAM_ADDR_io[MEM_AW-1:0];
      wr_data_d = SRAM_DATA_IN_io;
    end
  end

  assign conflict_d = conflict_q
                    | (w_rd_valid && (SRAM_DATA_t != {DW{1'b1}}))
                    | (w_is_wr && (SRAM_DATA_t != {DW{1'b0}}));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      conflict_q <= conflict_d;
    end
  end

  // The read port follows the pins: any cycle that enters or stays in
  // RD_VALID presents the same address that was latched for the read.
  perip_sram_array #(
    .MEM_AW (MEM_AW),
    .DW     (DW)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (w_commit),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .raddr_i (SRAM_ADDR_io[MEM_AW-1:0]),
    .rdata_o (w_rdata)
  );

  assign rd_valid         = w_rd_valid;
  assign SRAM_DATA_OUT_io = w_rd_valid ? w_rdata : '0;
  assign wr_commit        = w_commit;
  assign bus_conflict     = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_perip_sram_responder.sv
// ============================================================================
// tb_perip_sram_responder : scoreboard bench for perip_sram_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_perip_sram_responder;

  localparam int AW     = 22;
  localparam int DW     = 16;
  localparam int MEM_AW = 10;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          csn, oen, wrn;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dt;
  logic [DW-1:0] dout;
  logic          rd_valid, wr_commit, bus_conflict;

  perip_sram_responder #(
    .AW(AW), .DW(DW), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .SRAM_CSn_io      (csn),
    .SRAM_OEn_io      (oen),
    .SRAM_WRn_io      (wrn),
    .SRAM_ADDR_io     (addr),
    .SRAM_DATA_IN_io  (din),
    .SRAM_DATA_t      (dt),
    .SRAM_DATA_OUT_io (dout),
    .rd_valid         (rd_valid),
    .wr_commit        (wr_commit),
    .bus_conflict     (bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       rdq[$];
  int            wrq[$];
  logic [DW-1:0] mdl [int];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_en = 1'b0;
  bit            prev_valid = 1'b0;
  logic [DW-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int key(input logic [AW-1:0] a);
    return int'(a[MEM_AW-1:0]);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT produces a read or a commit.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid && !prev_valid) begin
        if (rdq.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = rdq.pop_front();
          check("rd_latency", cyc, e.due);
          check("rd_data", dout, e.data);
          last_data = e.data;
        end
      end else if (rd_valid) begin
        check("rd_hold", dout, last_data);
      end else begin
        check("out_idle_zero", dout, 0);
      end
      if (wr_commit) begin
        if (wrq.size() == 0) check("wr_unexpected", 1, 0);
        else check("wr_commit_cycle", cyc, wrq.pop_front());
      end
      prev_valid = rd_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic o, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] t);
    csn = c; oen = o; wrn = w; addr = a; din = d; dt = t;
  endtask

  task automatic idle(input int n);
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int n, input logic o);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, o, 1'b0, a, d, '0);
      #1 check("wr_no_commit_while_low", wr_commit, 0);
      tick();
      check("wr_no_rd_valid", rd_valid, 0);
    end
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    wrq.push_back(cyc);
    mdl[key(a)] = d;
    #1 check("wr_commit_on_release", wr_commit, 1);
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    drive(1'b0, 1'b0, 1'b1, a, '0, '1);
    rdq.push_back('{data: mdl[key(a)], due: cyc + RD_LAT});
    repeat (hold) tick();
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_wr_commit"}, wr_commit, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_conflict"}, bus_conflict, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: write then read back with exact latency
    do_write(22'h005, 16'h1234, 2, 1'b1);
    idle(1);
    do_read(22'h005, 4);
    idle(1);

    // 2: address change mid-wait restarts the latency
    do_write(22'h006, 16'h6666, 1, 1'b1);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 22'h005, '0, '1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 22'h006, '0, '1);
    rdq.push_back('{data: mdl[key(22'h006)], due: cyc + RD_LAT});
    repeat (4) tick();
    idle(2);

    // 3: OEn and WRn low together is a write
    do_write(22'h020, 16'hA5A5, 2, 1'b0);
    idle(1);
    do_read(22'h020, 3);
    idle(1);

    // 4: aliasing above the implemented depth
    do_write(22'h400, 16'hBEEF, 1, 1'b1);
    idle(1);
    do_read(22'h000, 3);
    idle(1);
    do_read(22'h3C0400, 3);
    idle(1);

    // 5: reset during an unreleased write discards it
    do_write(22'h010, 16'h1111, 1, 1'b1);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 22'h010, 16'h2222, '0);
    repeat (2) tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    #1 check_all_zero("rst_mid_write");
    tick();
    rst = 1'b0;
    idle(1);
    do_read(22'h010, 3);
    idle(1);
    check("no_conflict_so_far", bus_conflict, 0);

    // 6: controller drives during RD_VALID -> sticky conflict
    drive(1'b0, 1'b0, 1'b1, 22'h005, '0, '1);
    rdq.push_back('{data: mdl[key(22'h005)], due: cyc + RD_LAT});
    repeat (RD_LAT) tick();
    check("rd_valid_before_conflict", rd_valid, 1);
    drive(1'b0, 1'b0, 1'b1, 22'h005, '0, 16'h0000);
    tick();
    check("conflict_set", bus_conflict, 1);
    drive(1'b0, 1'b0, 1'b1, 22'h005, '0, '1);
    tick();
    idle(3);
    check("conflict_sticky", bus_conflict, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("conflict_cleared_by_rst", bus_conflict, 0);
    idle(1);

    // Write without the controller driving the bus
    drive(1'b0, 1'b1, 1'b0, 22'h030, 16'h0F0F, 16'h0001);
    tick();
    drive(1'b1, 1'b1, 1'b1, '0, '0, '1);
    wrq.push_back(cyc);
    mdl[key(22'h030)] = 16'h0F0F;
    tick();
    check("wr_conflict_set", bus_conflict, 1);
    idle(1);
    do_read(22'h030, 3);
    idle(2);

    check("rd_queue_drained", rdq.size(), 0);
    check("wr_queue_drained", wrq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
